wb_regfile: RTL and testbench

Writeback-side consumer of the MEM/WB pipeline register in the 16-bit CPU. It selects the writeback value (memory or ALU result), commits it into the architectural register file (R0–R7 plus SP, IH, RA and T), and serves two decode-stage read ports. An optional write-through bypass resolves the same-cycle WB→ID hazard.

---
 rtl/wb_regfile_pkg.sv | 24 ++
 rtl/wb_regfile_if.sv | 32 +++
 rtl/wb_regfile_rf_read_port.sv | 30 +++
 rtl/wb_regfile.sv | 74 +++++++
 tb/tb_wb_regfile.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared CPU definitions for the writeback register file: datapath width,
// architectural register indices and the writeback data select encoding.
package wb_regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 12;

  localparam logic [3:0] IDX_SP   = 4'd8;
  localparam logic [3:0] IDX_IH   = 4'd9;
  localparam logic [3:0] IDX_RA   = 4'd10;
  localparam logic [3:0] IDX_T    = 4'd11;
  localparam logic [3:0] IDX_NONE = 4'd15;

  typedef enum logic {
    WB_SEL_ALU = 1'b0,
    WB_SEL_MEM = 1'b1
  } wb_sel_e;

  // Indices 12..15 are reserved or "no destination" and never hold state.
  function automatic logic idx_is_arch(input logic [3:0] idx);
    return idx <= IDX_T;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback inputs, decode-stage read ports and the committed-write
// observation outputs of the register file.
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int W = DATA_W
);
  logic         memtoreg_i;
  logic [3:0]   regdst_i;
  logic         regwrite_i;
  logic [W-1:0] alures_i;
  logic [W-1:0] memres_i;
  logic [3:0]   raddr_a_i;
  logic [3:0]   raddr_b_i;
  logic [W-1:0] rdata_a_o;
  logic [W-1:0] rdata_b_o;
  logic         wb_fire_o;
  logic [3:0]   wb_dst_o;
  logic [W-1:0] wb_data_o;

  modport master (
    output memtoreg_i, regdst_i, regwrite_i, alures_i, memres_i,
    output raddr_a_i, raddr_b_i,
    input  rdata_a_o, rdata_b_o, wb_fire_o, wb_dst_o, wb_data_o
  );

  modport slave (
    input  memtoreg_i, regdst_i, regwrite_i, alures_i, memres_i,
    input  raddr_a_i, raddr_b_i,
    output rdata_a_o, rdata_b_o, wb_fire_o, wb_dst_o, wb_data_o
  );
endinterface

// File: rtl/wb_regfile_rf_read_port.sv
// One combinational register-file read port: index decode, zero for reserved
// indices and, when WB_BYPASS_EN is defined, write-through of the pending write.
module rf_read_port
  import wb_regfile_pkg::*;
(
  input  logic [3:0]        raddr_i,
  input  logic [DATA_W-1:0] regs_i [NUM_REGS],
  input  logic              wr_en_i,
  input  logic [3:0]        wr_idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

`ifndef WB_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en_i, wr_idx_i, wdata_i};
`endif

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr_i == 4'(i)) rdata_o = regs_i[i];
    end
`ifdef WB_BYPASS_EN
    // wr_en_i already excludes reserved/none indices, so they never bypass.
    if (wr_en_i && (raddr_i == wr_idx_i)) rdata_o = wdata_i;
`endif
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage register file: selects ALU/memory result, commits it to
// R0-R7/SP/IH/RA/T and serves two decode read ports (bypass: WB_BYPASS_EN).
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter logic [DATA_W-1:0] SP_RST = 16'h0000
) (
  input logic          CLK,
  input logic          RST,
  wb_regfile_if.slave  bus
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] wdata;
  logic              wr_en;
  wb_sel_e           wb_sel;

  logic              wb_fire_q;
  logic [3:0]        wb_dst_q;
  logic [DATA_W-1:0] wb_data_q;

  assign wb_sel = wb_sel_e'(bus.memtoreg_i);
  assign wdata  = (wb_sel == WB_SEL_MEM) ? bus.memres_i : bus.alures_i;
  assign wr_en  = bus.regwrite_i && idx_is_arch(bus.regdst_i);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      regs_q[IDX_SP] <= SP_RST;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && (bus.regdst_i == 4'(i))) regs_q[i] <= wdata;
      end
    end
  end

  // Observe registers keep the last committed write until the next one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wb_fire_q <= 1'b0;
      wb_dst_q  <= IDX_NONE;
      wb_data_q <= '0;
    end else begin
      wb_fire_q <= wr_en;
      if (wr_en) begin
        wb_dst_q  <= bus.regdst_i;
        wb_data_q <= wdata;
      end
    end
  end

  assign bus.wb_fire_o = wb_fire_q;
  assign bus.wb_dst_o  = wb_dst_q;
  assign bus.wb_data_o = wb_data_q;

  rf_read_port u_port_a (
    .raddr_i  (bus.raddr_a_i),
    .regs_i   (regs_q),
    .wr_en_i  (wr_en),
    .wr_idx_i (bus.regdst_i),
    .wdata_i  (wdata),
    .rdata_o  (bus.rdata_a_o)
  );

  rf_read_port u_port_b (
    .raddr_i  (bus.raddr_b_i),
    .regs_i   (regs_q),
    .wr_en_i  (wr_en),
    .wr_idx_i (bus.regdst_i),
    .wdata_i  (wdata),
    .rdata_o  (bus.rdata_b_o)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, ALU/load writes, null/reserved
// destinations, same-cycle read (WB_BYPASS_EN aware) and reset during a write.
module tb_wb_regfile;

  localparam logic [15:0] SP_RST_TB = 16'hFF00;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  wb_regfile_if #(.W(16)) bus ();

  wb_regfile #(.SP_RST(SP_RST_TB)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive_wb(input logic we, input logic mtr, input logic [3:0] dst,
                          input logic [15:0] alu, input logic [15:0] mem);
    bus.regwrite_i = we;
    bus.memtoreg_i = mtr;
    bus.regdst_i   = dst;
    bus.alures_i   = alu;
    bus.memres_i   = mem;
  endtask

  task automatic commit_edge();
    @(posedge clk);
    #1;
    bus.regwrite_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    rst = 1'b1;
    drive_wb(1'b0, 1'b0, 4'd0, 16'h0, 16'h0);
    bus.raddr_a_i = 4'd0;
    bus.raddr_b_i = 4'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_wb(1'b1, 1'b0, 4'd1, 16'h5555, 16'h0);
    commit_edge();
    bus.raddr_a_i = 4'd1;
    #1;
    total_cnt++;
    if (bus.rdata_a_o !== 16'h5555) $display("FAIL pre_reset_r1: got %h want %h", bus.rdata_a_o, 16'h5555);
    else pass_cnt++;
    // asynchronous assertion between edges
    rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      bus.raddr_a_i = 4'(i);
      bus.raddr_b_i = 4'(15 - i);
      #1;
      exp = (i == 8) ? SP_RST_TB : 16'h0000;
      total_cnt++;
      if (bus.rdata_a_o !== exp) $display("FAIL reset_read_a[%0d]: got %h want %h", i, bus.rdata_a_o, exp);
      else pass_cnt++;
      exp = (15 - i == 8) ? SP_RST_TB : 16'h0000;
      total_cnt++;
      if (bus.rdata_b_o !== exp) $display("FAIL reset_read_b[%0d]: got %h want %h", 15 - i, bus.rdata_b_o, exp);
      else pass_cnt++;
    end
    total_cnt++;
    if (bus.wb_fire_o !== 1'b0) $display("FAIL reset_fire: got %b want 0", bus.wb_fire_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.wb_dst_o !== 4'hF) $display("FAIL reset_dst: got %h want f", bus.wb_dst_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.wb_data_o !== 16'h0) $display("FAIL reset_data: got %h want 0000", bus.wb_data_o);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu_write();
    @(negedge clk);
    drive_wb(1'b1, 1'b0, 4'd3, 16'h1234, 16'hDEAD);
    commit_edge();
    bus.raddr_a_i = 4'd3;
    #1;
    total_cnt++;
    if (bus.rdata_a_o !== 16'h1234) $display("FAIL alu_r3: got %h want 1234", bus.rdata_a_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.wb_fire_o !== 1'b1) $display("FAIL alu_fire: got %b want 1", bus.wb_fire_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.wb_dst_o !== 4'd3) $display("FAIL alu_dst: got %h want 3", bus.wb_dst_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.wb_data_o !== 16'h1234) $display("FAIL alu_data: got %h want 1234", bus.wb_data_o);
    else pass_cnt++;
  endtask

  task automatic test_load_write();
    @(negedge clk);
    drive_wb(1'b1, 1'b1, 4'd8, 16'h0001, 16'hBEEF);
    commit_edge();
    bus.raddr_a_i = 4'd8;
    bus.raddr_b_i = 4'd3;
    #1;
    total_cnt++;
    if (bus.rdata_a_o !== 16'hBEEF) $display("FAIL load_sp: got %h want beef", bus.rdata_a_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.rdata_b_o !== 16'h1234) $display("FAIL load_r3_kept: got %h want 1234", bus.rdata_b_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.wb_dst_o !== 4'd8) $display("FAIL load_dst: got %h want 8", bus.wb_dst_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.wb_data_o !== 16'hBEEF) $display("FAIL load_data: got %h want beef", bus.wb_data_o);
    else pass_cnt++;
  endtask

  task automatic test_null_reserved();
    logic [3:0] dsts [2];
    dsts[0] = 4'd15;
    dsts[1] = 4'd13;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive_wb(1'b1, 1'b0, dsts[k], 16'hFFFF, 16'hFFFF);
      @(posedge clk);
      #1;
      bus.raddr_a_i = dsts[k];
      bus.raddr_b_i = 4'd3;
      #1;
      total_cnt++;
      if (bus.wb_fire_o !== 1'b0) $display("FAIL null_fire[%0d]: got %b want 0", dsts[k], bus.wb_fire_o);
      else pass_cnt++;
      total_cnt++;
      if (bus.wb_dst_o !== 4'd8) $display("FAIL null_dst_hold[%0d]: got %h want 8", dsts[k], bus.wb_dst_o);
      else pass_cnt++;
      total_cnt++;
      if (bus.wb_data_o !== 16'hBEEF) $display("FAIL null_data_hold[%0d]: got %h want beef", dsts[k], bus.wb_data_o);
      else pass_cnt++;
      total_cnt++;
      if (bus.rdata_a_o !== 16'h0) $display("FAIL null_read[%0d]: got %h want 0000", dsts[k], bus.rdata_a_o);
      else pass_cnt++;
      total_cnt++;
      if (bus.rdata_b_o !== 16'h1234) $display("FAIL null_r3_kept[%0d]: got %h want 1234", dsts[k], bus.rdata_b_o);
      else pass_cnt++;
      bus.raddr_b_i = 4'd8;
      #1;
      total_cnt++;
      if (bus.rdata_b_o !== 16'hBEEF) $display("FAIL null_sp_kept[%0d]: got %h want beef", dsts[k], bus.rdata_b_o);
      else pass_cnt++;
    end
    bus.regwrite_i = 1'b0;
  endtask

  task automatic test_bypass();
    logic [15:0] exp_pre;
`ifdef WB_BYPASS_EN
    exp_pre = 16'hA5A5;
`else
    exp_pre = 16'h0000;
`endif
    @(negedge clk);
    bus.raddr_a_i = 4'd4;
    bus.raddr_b_i = 4'd5;
    drive_wb(1'b1, 1'b0, 4'd5, 16'hA5A5, 16'h0);
    #1;
    total_cnt++;
    if (bus.rdata_b_o !== exp_pre) $display("FAIL bypass_pre_r5: got %h want %h", bus.rdata_b_o, exp_pre);
    else pass_cnt++;
    total_cnt++;
    if (bus.rdata_a_o !== 16'h0) $display("FAIL bypass_pre_r4: got %h want 0000", bus.rdata_a_o);
    else pass_cnt++;
    commit_edge();
    total_cnt++;
    if (bus.rdata_b_o !== 16'hA5A5) $display("FAIL bypass_post_r5: got %h want a5a5", bus.rdata_b_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.wb_dst_o !== 4'd5) $display("FAIL bypass_dst: got %h want 5", bus.wb_dst_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  dst [4];
    logic [15:0] val [4];
    dst[0] = 4'd0;  val[0] = 16'h0101;
    dst[1] = 4'd7;  val[1] = 16'h7070;
    dst[2] = 4'd9;  val[2] = 16'h0909;
    dst[3] = 4'd11; val[3] = 16'h0B0B;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      // odd entries come through the memory path, even through the ALU path
      if (k % 2 == 1) drive_wb(1'b1, 1'b1, dst[k], 16'h0000, val[k]);
      else            drive_wb(1'b1, 1'b0, dst[k], val[k], 16'hFFFF);
      @(posedge clk);
      #1;
      total_cnt++;
      if (bus.wb_fire_o !== 1'b1) $display("FAIL b2b_fire[%0d]: got %b want 1", k, bus.wb_fire_o);
      else pass_cnt++;
      total_cnt++;
      if (bus.wb_data_o !== val[k]) $display("FAIL b2b_data[%0d]: got %h want %h", k, bus.wb_data_o, val[k]);
      else pass_cnt++;
    end
    bus.regwrite_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.raddr_a_i = dst[k];
      bus.raddr_b_i = dst[k];
      #1;
      total_cnt++;
      if (bus.rdata_a_o !== val[k] || bus.rdata_b_o !== val[k])
        $display("FAIL b2b_read[%0d]: got a=%h b=%h want %h", dst[k], bus.rdata_a_o, bus.rdata_b_o, val[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_wb(1'b1, 1'b0, 4'd2, 16'h1111, 16'h0);
    commit_edge();
    @(negedge clk);
    drive_wb(1'b1, 1'b0, 4'd2, 16'h7777, 16'h0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    bus.regwrite_i = 1'b0;
    bus.raddr_a_i = 4'd2;
    #1;
    total_cnt++;
    if (bus.rdata_a_o !== 16'h0) $display("FAIL midrst_r2: got %h want 0000", bus.rdata_a_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.wb_fire_o !== 1'b0) $display("FAIL midrst_fire: got %b want 0", bus.wb_fire_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.wb_dst_o !== 4'hF) $display("FAIL midrst_dst: got %h want f", bus.wb_dst_o);
    else pass_cnt++;
    @(negedge clk);
    drive_wb(1'b1, 1'b0, 4'd2, 16'h7777, 16'h0);
    commit_edge();
    total_cnt++;
    if (bus.rdata_a_o !== 16'h7777) $display("FAIL midrst_rewrite_r2: got %h want 7777", bus.rdata_a_o);
    else pass_cnt++;
    total_cnt++;
    if (bus.wb_fire_o !== 1'b1 || bus.wb_dst_o !== 4'd2 || bus.wb_data_o !== 16'h7777)
      $display("FAIL midrst_observe: got fire=%b dst=%h data=%h want 1/2/7777",
               bus.wb_fire_o, bus.wb_dst_o, bus.wb_data_o);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_alu_write();
    test_load_write();
    test_null_reserved();
    test_bypass();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
